// File: rtl/xadc_scan_scheduler.sv
// xadc_scan_scheduler
// Periodically reads four XADC auxiliary channels (VAUX2, VAUX3, VAUX10 and
// VAUX11) over the DRP port. Keeps the latest 12-bit result per channel and
// derives two hysteresis-filtered button bits for the Pong top.
module xadc_scan_scheduler #(
  parameter int unsigned SCAN_DIV    = 1000000,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [11:0] TH_HIGH     = 12'd2867,
  parameter logic [11:0] TH_LOW      = 12'd2048
) (
  input  logic        CLK100MHZ,
  input  logic        RST_BTN,
  input  logic        enable,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [11:0] ch_data0,
  output logic [11:0] ch_data1,
  output logic [11:0] ch_data2,
  output logic [11:0] ch_data3,
  output logic [3:0]  ch_valid,
  output logic        scan_done,
  output logic [1:0]  BTN_LR,
  output logic        timeout_err
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // DRP address of each scanned channel, in scan order.
  function automatic logic [6:0] chan_addr(input logic [1:0] idx);
    logic [6:0] addr;
    case (idx)
      2'd0:    addr = 7'h12;
      2'd1:    addr = 7'h13;
      2'd2:    addr = 7'h1A;
      2'd3:    addr = 7'h1B;
      default: addr = 7'h12;
    endcase
    return addr;
  endfunction

  // Schmitt-trigger rule for one button bit.
  function automatic logic hyst_next(input logic prev, input logic [11:0] sample);
    logic nxt;
    if (sample >= TH_HIGH) begin
      nxt = 1'b1;
    end else if (sample < TH_LOW) begin
      nxt = 1'b0;
    end else begin
      nxt = prev;
    end
    return nxt;
  endfunction

  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_r;
  logic              pending_r;
  state_t            state_r;
  state_t            state_nx_s;
  logic [1:0]        idx_r;
  logic [1:0]        idx_nx_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic              start_s;
  logic              capture_s;
  logic              skip_s;
  logic [11:0]       sample_s;
  logic [3:0]        unused_lsb_s;

  // The XADC result is 12-bit left-justified; the low nibble carries no data.
  assign sample_s     = drp_do[15:4];
  assign unused_lsb_s = drp_do[3:0];
  assign drp_dwe      = 1'b0;

  // Scan timebase and one-deep request flag; extra ticks while pending are absorbed
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      tick_r     <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      if (tick_cnt_r == TICK_LAST) begin
        tick_cnt_r <= {TICK_W{1'b0}};
        tick_r     <= 1'b1;
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        tick_r     <= 1'b0;
      end
      if (start_s) begin
        pending_r <= 1'b0;
      end else if (tick_r && enable) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Next-state, channel index and per-cycle strobes of the scan sequencer
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    start_s    = 1'b0;
    capture_s  = 1'b0;
    skip_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r) begin
          state_nx_s = ISSUE;
          idx_nx_s   = 2'd0;
          start_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        state_nx_s = WAIT;
      end
      WAIT: begin
        if (drp_drdy) begin
          state_nx_s = STORE;
          capture_s  = 1'b1;
        end else if (to_cnt_r == TO_LAST) begin
          // Give up on this channel; keep its old data and move on.
          skip_s = 1'b1;
          if (idx_r == 2'd3) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = ISSUE;
            idx_nx_s   = idx_r + 2'd1;
          end
        end else begin
          state_nx_s = WAIT;
        end
      end
      STORE: begin
        if (idx_r == 2'd3) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = ISSUE;
          idx_nx_s   = idx_r + 2'd1;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Sequencer state, channel index and DRP response timeout counter
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      state_r  <= IDLE;
      idx_r    <= 2'd0;
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      if (state_r == ISSUE) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if ((state_r == WAIT) && !drp_drdy && !skip_s) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  // DRP strobe for the ISSUE cycle; address held until the next ISSUE
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      drp_den   <= 1'b0;
      drp_daddr <= 7'h00;
    end else begin
      drp_den <= (state_nx_s == ISSUE);
      if (state_nx_s == ISSUE) begin
        drp_daddr <= chan_addr(idx_nx_s);
      end else begin
        drp_daddr <= drp_daddr;
      end
    end
  end

  // Result capture and button hysteresis on the edge entering STORE, so the
  // new value is visible in STORE (the cycle after drdy)
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      ch_data0 <= 12'h000;
      ch_data1 <= 12'h000;
      ch_data2 <= 12'h000;
      ch_data3 <= 12'h000;
      ch_valid <= 4'h0;
      BTN_LR   <= 2'b00;
    end else if (capture_s) begin
      case (idx_r)
        2'd0:    ch_data0 <= sample_s;
        2'd1:    ch_data1 <= sample_s;
        2'd2:    ch_data2 <= sample_s;
        2'd3:    ch_data3 <= sample_s;
        default: ch_data0 <= ch_data0;
      endcase
      ch_valid <= ch_valid | (4'b0001 << idx_r);
      if (idx_r == 2'd0) begin
        BTN_LR[1] <= hyst_next(BTN_LR[1], sample_s);
      end else if (idx_r == 2'd1) begin
        BTN_LR[0] <= hyst_next(BTN_LR[0], sample_s);
      end else begin
        BTN_LR <= BTN_LR;
      end
    end else begin
      ch_valid <= ch_valid;
    end
  end

  // End-of-scan pulse and sticky timeout flag
  always_ff @(posedge CLK100MHZ) begin
    if (RST_BTN) begin
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      scan_done   <= (state_nx_s == DONE);
      timeout_err <= timeout_err | skip_s;
    end
  end

endmodule

// File: tb/tb_xadc_scan_scheduler.sv
// Bench for xadc_scan_scheduler: a DRP responder answers reads with
// per-scan channel values and a reference model tracks the expected
// results from the channel/address map and the hysteresis rule.
`timescale 1ns/1ps
module tb_xadc_scan_scheduler;

  localparam int unsigned SCAN_DIV = 100;
  localparam int unsigned TO_CYC   = 8;
  localparam logic [11:0] TH_HIGH  = 12'd2867;
  localparam logic [11:0] TH_LOW   = 12'd2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [11:0] ch_data0, ch_data1, ch_data2, ch_data3;
  logic [3:0]  ch_valid;
  logic        scan_done;
  logic [1:0]  BTN_LR;
  logic        timeout_err;

  always #5 clk = ~clk;

  xadc_scan_scheduler #(
    .SCAN_DIV(SCAN_DIV), .TIMEOUT_CYC(TO_CYC), .TH_HIGH(TH_HIGH), .TH_LOW(TH_LOW)
  ) dut (
    .CLK100MHZ(clk), .RST_BTN(rst), .enable(enable),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .ch_data0(ch_data0), .ch_data1(ch_data1), .ch_data2(ch_data2), .ch_data3(ch_data3),
    .ch_valid(ch_valid), .scan_done(scan_done), .BTN_LR(BTN_LR), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // responder controls and manual drdy injection
  logic        resp_en;
  int          resp_delay;
  int          resp_withhold;
  logic        resp_stray;
  logic        resp_drdy, man_drdy;
  logic [15:0] resp_do, man_do;
  logic [15:0] scan_val [4];
  logic [11:0] vis_seen [4];
  assign drp_drdy = resp_drdy | man_drdy;
  assign drp_do   = man_drdy ? man_do : resp_do;

  // reference model
  logic [11:0] exp_data [4];
  logic [3:0]  exp_valid;
  logic [1:0]  exp_btn;
  logic        exp_terr;
  logic [6:0]  exp_addr [4] = '{7'h12, 7'h13, 7'h1A, 7'h1B};

  // monitor
  int         den_cnt = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  logic [6:0] addr_q [$];
  int         den_base, done_base, addr_base;

  always @(negedge clk) begin
    if (drp_den === 1'b1) begin
      den_cnt <= den_cnt + 1;
      addr_q.push_back(drp_daddr);
    end
    if (scan_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int chan_of(input logic [6:0] a);
    case (a)
      7'h12:   return 0;
      7'h13:   return 1;
      7'h1A:   return 2;
      7'h1B:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [11:0] ch_out(input int ch);
    case (ch)
      0:       return ch_data0;
      1:       return ch_data1;
      2:       return ch_data2;
      3:       return ch_data3;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic hyst(input logic prev, input logic [11:0] x);
    if (x >= TH_HIGH) return 1'b1;
    if (x < TH_LOW)   return 1'b0;
    return prev;
  endfunction

  // DRP responder: drdy resp_delay cycles after den, optional stray drdy in the den cycle
  initial begin : responder
    int ch;
    resp_drdy = 1'b0;
    resp_do   = 16'h0000;
    for (int i = 0; i < 4; i++) vis_seen[i] = 12'h000;
    forever begin
      @(negedge clk);
      ch = chan_of(drp_daddr);
      if (resp_en && drp_den === 1'b1 && ch >= 0 && ch != resp_withhold) begin
        resp_drdy = resp_stray;
        resp_do   = ~scan_val[ch];
        for (int k = 0; k < resp_delay; k++) begin
          @(posedge clk); #1;
          resp_drdy = 1'b0;
          resp_do   = 16'($urandom);
        end
        resp_drdy = 1'b1;
        resp_do   = scan_val[ch];
        @(posedge clk); #1;
        resp_drdy = 1'b0;
        resp_do   = 16'($urandom);
        @(negedge clk);
        vis_seen[ch] = ch_out(ch);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_data[i] = 12'h000;
    exp_valid = 4'h0;
    exp_btn   = 2'b00;
    exp_terr  = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic prep_scan(input int withhold, input int delay);
    resp_withhold = withhold;
    resp_delay    = (delay > 0) ? delay : int'($urandom_range(1, 5));
    den_base      = den_cnt;
    done_base     = done_cnt;
    addr_base     = addr_q.size();
  endtask

  task automatic finish_scan();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL scan_done_wait: no scan_done within %0d cycles", 3 * SCAN_DIV);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == resp_withhold) begin
        exp_terr = 1'b1;
      end else begin
        exp_data[i]  = scan_val[i][15:4];
        exp_valid[i] = 1'b1;
        if (i == 0) exp_btn[1] = hyst(exp_btn[1], scan_val[i][15:4]);
        if (i == 1) exp_btn[0] = hyst(exp_btn[0], scan_val[i][15:4]);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b1; man_drdy = 1'b1; man_do = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests += 11;
    if (drp_den !== 1'b0)     begin n_fail++; $display("FAIL rst_den: got %b want 0", drp_den); end
    if (drp_daddr !== 7'h00)  begin n_fail++; $display("FAIL rst_daddr: got %h want 00", drp_daddr); end
    if (drp_dwe !== 1'b0)     begin n_fail++; $display("FAIL rst_dwe: got %b want 0", drp_dwe); end
    if (ch_valid !== 4'h0)    begin n_fail++; $display("FAIL rst_valid: got %h want 0", ch_valid); end
    if (scan_done !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b want 0", scan_done); end
    if (BTN_LR !== 2'b00)     begin n_fail++; $display("FAIL rst_btn: got %b want 00", BTN_LR); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    for (int i = 0; i < 4; i++)
      if (ch_out(i) !== 12'h000) begin n_fail++; $display("FAIL rst_data%0d: got %h want 000", i, ch_out(i)); end
    @(posedge clk); #1;
    rst = 1'b0; man_drdy = 1'b0;
    model_reset();
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 4; i++) scan_val[i] = 16'hB330;
    prep_scan(-1, 3);
    finish_scan();
    n_tests += 5;
    if (den_cnt - den_base != 4)  begin n_fail++; $display("FAIL nom_den_count: got %0d want 4", den_cnt - den_base); end
    if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", done_cnt - done_base); end
    if (ch_valid !== 4'hF)  begin n_fail++; $display("FAIL nom_valid: got %h want F", ch_valid); end
    if (BTN_LR !== 2'b11)   begin n_fail++; $display("FAIL nom_btn: got %b want 11", BTN_LR); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL nom_terr: got %b want 0", timeout_err); end
    for (int i = 0; i < 4; i++) begin
      n_tests += 3;
      if (ch_out(i) !== 12'hB33)  begin n_fail++; $display("FAIL nom_data%0d: got %h want B33", i, ch_out(i)); end
      if (vis_seen[i] !== 12'hB33) begin n_fail++; $display("FAIL nom_visible%0d: got %h want B33", i, vis_seen[i]); end
      if (addr_q.size() <= addr_base + i || addr_q[addr_base + i] !== exp_addr[i]) begin
        n_fail++; $display("FAIL nom_addr%0d: want %h", i, exp_addr[i]);
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [11:0] hin [4] = '{12'd3000, 12'd2500, 12'd2000, 12'd2500};
    logic [3:0]  hexp = 4'b0011;
    for (int s = 0; s < 4; s++) begin
      scan_val[0] = {hin[s], 4'($urandom)};
      for (int i = 1; i < 4; i++) scan_val[i] = 16'($urandom);
      prep_scan(-1, 0);
      finish_scan();
      n_tests += 2;
      if (BTN_LR[1] !== hexp[s]) begin n_fail++; $display("FAIL hyst_left%0d: got %b want %b", s, BTN_LR[1], hexp[s]); end
      if (BTN_LR[0] !== exp_btn[0]) begin n_fail++; $display("FAIL hyst_right%0d: got %b want %b", s, BTN_LR[0], exp_btn[0]); end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 4; i++) scan_val[i] = 16'($urandom);
      prep_scan(-1, 0);
      finish_scan();
      n_tests += 2;
      if (BTN_LR !== exp_btn)     begin n_fail++; $display("FAIL rnd_btn%0d: got %b want %b", s, BTN_LR, exp_btn); end
      if (ch_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid%0d: got %h want %h", s, ch_valid, exp_valid); end
      for (int i = 0; i < 4; i++) begin
        n_tests += 3;
        if (ch_out(i) !== exp_data[i])   begin n_fail++; $display("FAIL rnd_data%0d_%0d: got %h want %h", s, i, ch_out(i), exp_data[i]); end
        if (vis_seen[i] !== exp_data[i]) begin n_fail++; $display("FAIL rnd_visible%0d_%0d: got %h want %h", s, i, vis_seen[i], exp_data[i]); end
        if (addr_q.size() <= addr_base + i || addr_q[addr_base + i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL rnd_addr%0d_%0d: want %h", s, i, exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit found;
    for (int i = 0; i < 4; i++) scan_val[i] = 16'($urandom);
    scan_val[2] = {~exp_data[2], 4'h0};
    prep_scan(2, 0);
    found = 1'b0;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (drp_den === 1'b1 && drp_daddr === 7'h1A) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL to_den_idx2: no read of 1A seen"); end
    repeat (TO_CYC) @(negedge clk);
    n_tests++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0 after %0d cycles", timeout_err, TO_CYC - 1); end
    @(negedge clk);
    n_tests += 2;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b want 1", timeout_err); end
    if (drp_den !== 1'b1 || drp_daddr !== 7'h1B) begin
      n_fail++; $display("FAIL to_next_read: den %b addr %h want 1 1B", drp_den, drp_daddr);
    end
    finish_scan();
    n_tests += 4;
    if (ch_data2 !== exp_data[2]) begin n_fail++; $display("FAIL to_data2_kept: got %h want %h", ch_data2, exp_data[2]); end
    if (ch_data3 !== exp_data[3]) begin n_fail++; $display("FAIL to_data3: got %h want %h", ch_data3, exp_data[3]); end
    if (ch_valid !== exp_valid)   begin n_fail++; $display("FAIL to_valid: got %h want %h", ch_valid, exp_valid); end
    if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL to_done_count: got %0d want 1", done_cnt - done_base); end
  endtask

  task automatic test_stray();
    enable = 1'b0;
    den_base  = den_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    man_drdy = 1'b1; man_do = 16'h5A5A;
    @(posedge clk); #1;
    man_drdy = 1'b0;
    repeat (20) @(negedge clk);
    n_tests += 2;
    if (den_cnt != den_base || done_cnt != done_base) begin
      n_fail++; $display("FAIL stray_idle_activity: den %0d done %0d want 0 0", den_cnt - den_base, done_cnt - done_base);
    end
    if (ch_data0 !== exp_data[0] || ch_data1 !== exp_data[1] || ch_data2 !== exp_data[2] || ch_data3 !== exp_data[3]) begin
      n_fail++; $display("FAIL stray_idle_data: got %h %h %h %h", ch_data0, ch_data1, ch_data2, ch_data3);
    end
    enable = 1'b1;
    resp_stray = 1'b1;
    for (int i = 0; i < 4; i++) scan_val[i] = 16'($urandom);
    prep_scan(-1, 0);
    finish_scan();
    resp_stray = 1'b0;
    n_tests += 3;
    if (den_cnt - den_base != 4) begin n_fail++; $display("FAIL stray_issue_den: got %0d want 4", den_cnt - den_base); end
    if (BTN_LR !== exp_btn)      begin n_fail++; $display("FAIL stray_issue_btn: got %b want %b", BTN_LR, exp_btn); end
    if (timeout_err !== 1'b1)    begin n_fail++; $display("FAIL terr_sticky: got %b want 1", timeout_err); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ch_out(i) !== exp_data[i]) begin n_fail++; $display("FAIL stray_issue_data%0d: got %h want %h", i, ch_out(i), exp_data[i]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    resp_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (drp_den === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rmw_den: no read started"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; man_drdy = 1'b1; man_do = 16'hFFF0;
    @(posedge clk); #1;
    man_drdy = 1'b0;
    model_reset();
    @(negedge clk);
    n_tests += 8;
    if (drp_den !== 1'b0 || drp_daddr !== 7'h00) begin n_fail++; $display("FAIL rmw_drp: den %b addr %h want 0 00", drp_den, drp_daddr); end
    if (ch_valid !== 4'h0)    begin n_fail++; $display("FAIL rmw_valid: got %h want 0", ch_valid); end
    if (BTN_LR !== 2'b00)     begin n_fail++; $display("FAIL rmw_btn: got %b want 00", BTN_LR); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmw_terr: got %b want 0", timeout_err); end
    if (scan_done !== 1'b0)   begin n_fail++; $display("FAIL rmw_done: got %b want 0", scan_done); end
    for (int i = 0; i < 3; i++)
      if (ch_out(i) !== 12'h000) begin n_fail++; $display("FAIL rmw_data%0d: got %h want 000", i, ch_out(i)); end
    n_tests++;
    if (ch_data3 !== 12'h000) begin n_fail++; $display("FAIL rmw_data3: got %h want 000", ch_data3); end
    den_base = den_cnt;
    while (cyc < 90) @(negedge clk);
    n_tests++;
    if (den_cnt != den_base) begin n_fail++; $display("FAIL rmw_idle_until_tick: got %0d reads want 0", den_cnt - den_base); end
    resp_en = 1'b1;
    for (int i = 0; i < 4; i++) scan_val[i] = 16'($urandom);
    prep_scan(-1, 0);
    finish_scan();
    n_tests++;
    if (ch_valid !== 4'hF) begin n_fail++; $display("FAIL rmw_rescan_valid: got %h want F", ch_valid); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ch_out(i) !== exp_data[i]) begin n_fail++; $display("FAIL rmw_rescan_data%0d: got %h want %h", i, ch_out(i), exp_data[i]); end
    end
  endtask

  task automatic test_enable_gating();
    int den_cyc;
    enable = 1'b0;
    apply_reset();
    den_base = den_cnt;
    while (cyc < 350) @(negedge clk);
    n_tests++;
    if (den_cnt != den_base) begin n_fail++; $display("FAIL gate_disabled: got %0d reads want 0", den_cnt - den_base); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) scan_val[i] = 16'($urandom);
    prep_scan(-1, 0);
    den_cyc = -1;
    while (cyc < 500) begin
      @(negedge clk);
      if (drp_den === 1'b1) begin
        den_cyc = cyc;
        break;
      end
    end
    n_tests++;
    if (den_cyc <= 390 || den_cyc >= 430) begin
      n_fail++; $display("FAIL gate_first_scan: first read at cycle %0d want between 390 and 430", den_cyc);
    end
    finish_scan();
    n_tests += 2;
    if (den_cnt - den_base != 4) begin n_fail++; $display("FAIL gate_den_count: got %0d want 4", den_cnt - den_base); end
    if (BTN_LR !== exp_btn)      begin n_fail++; $display("FAIL gate_btn: got %b want %b", BTN_LR, exp_btn); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ch_out(i) !== exp_data[i]) begin n_fail++; $display("FAIL gate_data%0d: got %h want %h", i, ch_out(i), exp_data[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    man_drdy = 1'b0; man_do = 16'h0000;
    resp_en = 1'b1; resp_withhold = -1; resp_stray = 1'b0; resp_delay = 3;
    for (int i = 0; i < 4; i++) scan_val[i] = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    test_reset();
    test_nominal();
    test_hysteresis();
    test_random();
    test_timeout();
    test_stray();
    test_reset_mid_wait();
    test_enable_gating();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
